// File: rtl/lsu_pkg.sv
// Shared op codes, FSM state encoding and access-size helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  function automatic lsu_size_e opSize(lsu_op_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
      LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

  function automatic logic isStore(lsu_op_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  // Natural alignment: halves on even addresses, words on multiples of four.
  function automatic logic isMisaligned(lsu_op_e op, logic [1:0] off);
    case (opSize(op))
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-oriented memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              MemReq;
  logic              MemGnt;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [3:0]        MemBe;
  logic [31:0]       MemWData;
  logic              MemRValid;
  logic [31:0]       MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemBe, MemWData,
    input  MemGnt, MemRValid, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemBe, MemWData,
    output MemGnt, MemRValid, MemRData
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store data per access phase,
// plus load extraction/extension from one or two returned words.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_e     i_Op,
  input  logic [1:0]  i_Offset,
  input  logic        i_Phase,
  input  logic [31:0] i_StoreData,
  input  logic [31:0] i_Word0,
  input  logic [31:0] i_Word1,
  output logic [31:0] o_LoadData,
  output logic [3:0]  o_MemBe,
  output logic [31:0] o_MemWData,
  output logic        o_Cross
);

  logic [3:0]  w_base;
  logic [31:0] w_sdMasked;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic [31:0] w_rd;

  always_comb begin
    w_base     = 4'b1111;
    w_sdMasked = i_StoreData;
    case (opSize(i_Op))
      SZ_BYTE: begin w_base = 4'b0001; w_sdMasked = {24'h0, i_StoreData[7:0]};  end
      SZ_HALF: begin w_base = 4'b0011; w_sdMasked = {16'h0, i_StoreData[15:0]}; end
      default: begin w_base = 4'b1111; w_sdMasked = i_StoreData;                end
    endcase
  end

  // Shifting into a double-word view puts lanes that spill past the word into the upper half.
  assign w_be8   = {4'b0000, w_base} << i_Offset;
  assign w_wd64  = {32'h0, w_sdMasked} << {i_Offset, 3'b000};
  assign w_rd    = 32'({i_Word1, i_Word0} >> {i_Offset, 3'b000});

  assign o_MemBe    = i_Phase ? w_be8[7:4]   : w_be8[3:0];
  assign o_MemWData = i_Phase ? w_wd64[63:32] : w_wd64[31:0];
  assign o_Cross    = |w_be8[7:4];

  always_comb begin
    o_LoadData = 32'h0;
    case (i_Op)
      LSU_LB:  o_LoadData = {{24{w_rd[7]}}, w_rd[7:0]};
      LSU_LH:  o_LoadData = {{16{w_rd[15]}}, w_rd[15:0]};
      LSU_LW:  o_LoadData = w_rd;
      LSU_LBU: o_LoadData = {24'h0, w_rd[7:0]};
      LSU_LHU: o_LoadData = {16'h0, w_rd[15:0]};
      default: o_LoadData = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one op at a time over a word bus with request/grant and read-valid.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned ops (split across words); otherwise they fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        DataMemControl,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       StoreData,
  output logic              RespValid,
  output logic [31:0]       LoadData,
  output logic              AccessFault,
  load_store_unit_if.master mem
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SplitEn = 1'b1;
`else
  localparam logic SplitEn = 1'b0;
`endif

  lsu_state_e        r_state;
  lsu_op_e           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_sd;
  logic [31:0]       r_word0;
  logic              r_cross;
  logic              r_ReqReady;
  logic              r_RespValid;
  logic [31:0]       r_LoadData;
  logic              r_AccessFault;
  logic              r_MemReq;
  logic              r_MemWe;
  logic [ADDR_W-1:0] r_MemAddr;
  logic [3:0]        r_MemBe;
  logic [31:0]       r_MemWData;

  logic              w_idle;
  lsu_op_e           w_op;
  logic [1:0]        w_off;
  logic [31:0]       w_sd;
  logic [31:0]       w_word0;
  logic [31:0]       w_word1;
  logic [31:0]       w_LoadData;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_cross;
  logic              w_fault;
  logic [ADDR_W-1:0] w_wordAddr;
  logic [ADDR_W-1:0] w_nextAddr;

  // In IDLE the aligner sees the incoming request so the first access can issue on accept.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_op       = w_idle ? lsu_op_e'(DataMemControl) : r_op;
  assign w_off      = w_idle ? Addr[1:0] : r_addr[1:0];
  assign w_sd       = w_idle ? StoreData : r_sd;
  assign w_word0    = (r_state == ST_WAIT1) ? r_word0 : mem.MemRData;
  assign w_word1    = (r_state == ST_WAIT1) ? mem.MemRData : 32'h0;
  assign w_fault    = isMisaligned(w_op, w_off) && !SplitEn;
  assign w_wordAddr = {Addr[ADDR_W-1:2], 2'b00};
  assign w_nextAddr = {r_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);

  lsu_align u_align (
    .i_Op        (w_op),
    .i_Offset    (w_off),
    .i_Phase     (!w_idle),
    .i_StoreData (w_sd),
    .i_Word0     (w_word0),
    .i_Word1     (w_word1),
    .o_LoadData  (w_LoadData),
    .o_MemBe     (w_be),
    .o_MemWData  (w_wdata),
    .o_Cross     (w_cross)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= LSU_LB;
      r_addr        <= '0;
      r_sd          <= 32'h0;
      r_word0       <= 32'h0;
      r_cross       <= 1'b0;
      r_ReqReady    <= 1'b1;
      r_RespValid   <= 1'b0;
      r_LoadData    <= 32'h0;
      r_AccessFault <= 1'b0;
      r_MemReq      <= 1'b0;
      r_MemWe       <= 1'b0;
      r_MemAddr     <= '0;
      r_MemBe       <= 4'h0;
      r_MemWData    <= 32'h0;
    end else begin
      r_RespValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ReqValid) begin
            r_op          <= w_op;
            r_addr        <= Addr;
            r_sd          <= StoreData;
            r_cross       <= w_cross & SplitEn;
            r_ReqReady    <= 1'b0;
            r_AccessFault <= w_fault;
            r_LoadData    <= 32'h0;
            if (w_fault) begin
              r_state     <= ST_RESP;
              r_RespValid <= 1'b1;
            end else begin
              r_state    <= ST_REQ0;
              r_MemReq   <= 1'b1;
              r_MemWe    <= isStore(w_op);
              r_MemAddr  <= w_wordAddr;
              r_MemBe    <= w_be;
              r_MemWData <= isStore(w_op) ? w_wdata : 32'h0;
            end
          end
        end
        ST_REQ0, ST_REQ1: begin
          if (mem.MemGnt) begin
            r_MemReq   <= 1'b0;
            r_MemWe    <= 1'b0;
            r_MemAddr  <= '0;
            r_MemBe    <= 4'h0;
            r_MemWData <= 32'h0;
            if (!isStore(r_op)) begin
              r_state <= (r_state == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
            end else if ((r_state == ST_REQ0) && r_cross) begin
              r_state    <= ST_REQ1;
              r_MemReq   <= 1'b1;
              r_MemWe    <= 1'b1;
              r_MemAddr  <= w_nextAddr;
              r_MemBe    <= w_be;
              r_MemWData <= w_wdata;
            end else begin
              r_state     <= ST_RESP;
              r_RespValid <= 1'b1;
            end
          end
        end
        ST_WAIT0: begin
          if (mem.MemRValid) begin
            if (r_cross) begin
              r_word0   <= mem.MemRData;
              r_state   <= ST_REQ1;
              r_MemReq  <= 1'b1;
              r_MemWe   <= 1'b0;
              r_MemAddr <= w_nextAddr;
              r_MemBe   <= w_be;
            end else begin
              r_LoadData  <= w_LoadData;
              r_state     <= ST_RESP;
              r_RespValid <= 1'b1;
            end
          end
        end
        ST_WAIT1: begin
          if (mem.MemRValid) begin
            r_LoadData  <= w_LoadData;
            r_state     <= ST_RESP;
            r_RespValid <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          r_ReqReady <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ReqReady <= 1'b1;
        end
      endcase
    end
  end

  assign ReqReady     = r_ReqReady;
  assign RespValid    = r_RespValid;
  assign LoadData     = r_LoadData;
  assign AccessFault  = r_AccessFault;
  assign mem.MemReq   = r_MemReq;
  assign mem.MemWe    = r_MemWe;
  assign mem.MemAddr  = r_MemAddr;
  assign mem.MemBe    = r_MemBe;
  assign mem.MemWData = r_MemWData;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference model, randomized memory timing.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  DataMemControl;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        RespValid;
  logic [31:0] LoadData;
  logic        AccessFault;

  load_store_unit_if #(.ADDR_W(32)) memBus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .DataMemControl (DataMemControl),
    .Addr           (Addr),
    .StoreData      (StoreData),
    .RespValid      (RespValid),
    .LoadData       (LoadData),
    .AccessFault    (AccessFault),
    .mem            (memBus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memExp_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } respExp_t;

  memExp_t    memQ[$];
  respExp_t   respQ[$];
  logic [7:0] memb [logic [31:0]];

  int total = 0;
  int bad   = 0;
  bit fastMem = 1'b0;
  int forceGntDelay = -1;
  bit rdHold = 1'b0;
  bit lateRValid = 1'b0;
  int grantCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNote(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [7:0] memRead(input logic [31:0] a);
    if (memb.exists(a)) return memb[a];
    return 8'((a * 37) + (a >> 8) + 11);
  endfunction

  function automatic int opBytes(input int op);
    case (op)
      0, 3, 5: return 1;
      1, 4, 6: return 2;
      default: return 4;
    endcase
  endfunction

  // Reference: split the op into the bytes it touches, group them per word, and assemble loads byte by byte.
  task automatic modelOp(input int op, input logic [31:0] a, input logic [31:0] sd);
    int          n;
    bit          st;
    respExp_t    r;
    memExp_t     m;
    logic [31:0] words[$];
    logic [31:0] v;
    logic [31:0] b;
    logic [31:0] lastW;
    int          lane;
    n = opBytes(op);
    st = (op >= 5);
    r.data = 32'h0;
    r.fault = 1'b0;
    if (((a % n) != 0) && !SplitEn) begin
      r.fault = 1'b1;
      respQ.push_back(r);
      return;
    end
    words.push_back(a & ~32'd3);
    lastW = (a + n - 1) & ~32'd3;
    if (lastW != words[0]) words.push_back(lastW);
    foreach (words[k]) begin
      m.addr = words[k];
      m.we = st;
      m.be = 4'h0;
      m.wdata = 32'h0;
      for (int i = 0; i < n; i++) begin
        b = a + i;
        if ((b & ~32'd3) == words[k]) begin
          lane = int'(b % 4);
          m.be[lane] = 1'b1;
          if (st) m.wdata[8*lane +: 8] = sd[8*i +: 8];
        end
      end
      memQ.push_back(m);
    end
    if (!st) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = memRead(a + i);
      if (op == 0 && v[7])  v = v | 32'hFFFFFF00;
      if (op == 1 && v[15]) v = v | 32'hFFFF0000;
      r.data = v;
    end
    respQ.push_back(r);
  endtask

  // Memory responder: checks each requested cycle against the model, grants after a delay, returns reads later.
  initial begin
    int          gntCnt;
    int          rdCnt;
    bit          pending;
    bit          inReq;
    logic [31:0] rdWord;
    memExp_t     e;
    gntCnt = 0;
    rdCnt = 0;
    pending = 1'b0;
    inReq = 1'b0;
    rdWord = 32'h0;
    memBus.MemGnt = 1'b0;
    memBus.MemRValid = 1'b0;
    memBus.MemRData = 32'h0;
    forever begin
      @(negedge clk);
      memBus.MemGnt = 1'b0;
      memBus.MemRValid = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        inReq = 1'b0;
        continue;
      end
      if (lateRValid) begin
        memBus.MemRValid = 1'b1;
        memBus.MemRData = 32'hCAFEF00D;
        lateRValid = 1'b0;
      end else if (pending) begin
        if (rdCnt > 0) rdCnt--;
        else if (!rdHold) begin
          memBus.MemRValid = 1'b1;
          memBus.MemRData = rdWord;
          pending = 1'b0;
        end
      end else if (!fastMem && $urandom_range(0, 7) == 0) begin
        memBus.MemRValid = 1'b1;
        memBus.MemRData = $urandom;
      end
      if (memBus.MemReq) begin
        if (!inReq) begin
          inReq = 1'b1;
          gntCnt = (forceGntDelay >= 0) ? forceGntDelay : (fastMem ? 0 : $urandom_range(0, 3));
        end
        checkOutput("ReqReady while MemReq", 32'(ReqReady), 32'h0);
        if (memQ.size() == 0) failNote("unexpected MemReq");
        else begin
          e = memQ[0];
          checkOutput("MemAddr", memBus.MemAddr, e.addr);
          checkOutput("MemWe", 32'(memBus.MemWe), 32'(e.we));
          checkOutput("MemBe", 32'(memBus.MemBe), 32'(e.be));
          checkOutput("MemWData", memBus.MemWData, e.wdata);
        end
        if (gntCnt == 0) begin
          memBus.MemGnt = 1'b1;
          grantCount++;
          inReq = 1'b0;
          if (memQ.size() != 0) void'(memQ.pop_front());
          if (memBus.MemWe) begin
            for (int j = 0; j < 4; j++)
              if (memBus.MemBe[j]) memb[memBus.MemAddr + j] = memBus.MemWData[8*j +: 8];
          end else begin
            for (int j = 0; j < 4; j++) rdWord[8*j +: 8] = memRead(memBus.MemAddr + j);
            pending = 1'b1;
            rdCnt = fastMem ? 0 : $urandom_range(0, 2);
          end
        end else begin
          gntCnt--;
        end
      end
    end
  end

  // Response monitor: every RespValid pops the oldest expected response.
  initial begin
    respExp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && RespValid) begin
        if (respQ.size() == 0) failNote("unexpected RespValid");
        else begin
          e = respQ.pop_front();
          checkOutput("LoadData", LoadData, e.data);
          checkOutput("AccessFault", 32'(AccessFault), 32'(e.fault));
          checkOutput("accesses left at resp", 32'(memQ.size()), 32'h0);
        end
      end
    end
  end

  // Issues one op, keeps garbage on the request pins while busy, returns negedges from drive to RespValid.
  task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] sd,
                               output int lat, output logic [31:0] data, output logic fault);
    int guard;
    guard = 0;
    while (!ReqReady && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    modelOp(op, a, sd);
    ReqValid = 1'b1;
    DataMemControl = 3'(op);
    Addr = a;
    StoreData = sd;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (RespValid) break;
      ReqValid = 1'($urandom_range(0, 1));
      DataMemControl = 3'($urandom);
      Addr = $urandom;
      StoreData = $urandom;
    end
    if (!RespValid) failNote("response timeout");
    data = LoadData;
    fault = AccessFault;
    ReqValid = 1'b0;
    @(negedge clk);
    checkOutput("RespValid one cycle", 32'(RespValid), 32'h0);
    checkOutput("ReqReady after resp", 32'(ReqReady), 32'h1);
  endtask

  initial begin
    int          lat;
    int          g;
    logic [31:0] d;
    logic        f;
    memExp_t     m;
    ReqValid = 1'b0;
    DataMemControl = 3'd0;
    Addr = 32'h0;
    StoreData = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset ReqReady", 32'(ReqReady), 32'h1);
    checkOutput("reset RespValid", 32'(RespValid), 32'h0);
    checkOutput("reset AccessFault", 32'(AccessFault), 32'h0);
    checkOutput("reset LoadData", LoadData, 32'h0);
    checkOutput("reset MemReq", 32'(memBus.MemReq), 32'h0);
    checkOutput("reset MemWe", 32'(memBus.MemWe), 32'h0);
    checkOutput("reset MemBe", 32'(memBus.MemBe), 32'h0);
    checkOutput("reset MemAddr", memBus.MemAddr, 32'h0);
    checkOutput("reset MemWData", memBus.MemWData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    fastMem = 1'b1;
    applyStimulus(7, 32'h100, 32'hDEADBEEF, lat, d, f);
    checkOutput("sw latency", 32'(lat), 32'd2);

    memb[32'h200] = 8'h00; memb[32'h201] = 8'h00; memb[32'h202] = 8'h00; memb[32'h203] = 8'h80;
    applyStimulus(0, 32'h203, 32'h0, lat, d, f);
    checkOutput("lb 0x203", d, 32'hFFFFFF80);
    checkOutput("load latency", 32'(lat), 32'd3);
    applyStimulus(3, 32'h203, 32'h0, lat, d, f);
    checkOutput("lbu 0x203", d, 32'h00000080);

    applyStimulus(6, 32'h302, 32'h00001234, lat, d, f);
    checkOutput("sh 0x302 memory", {memb[32'h303], memb[32'h302]}, 32'h1234);

    memb[32'h400] = 8'h11; memb[32'h401] = 8'h22; memb[32'h402] = 8'h33; memb[32'h403] = 8'h44;
    memb[32'h404] = 8'h55; memb[32'h405] = 8'h66; memb[32'h406] = 8'h77; memb[32'h407] = 8'h88;
    g = grantCount;
    applyStimulus(2, 32'h401, 32'h0, lat, d, f);
    checkOutput("lw 0x401 data", d, SplitEn ? 32'h55443322 : 32'h0);
    checkOutput("lw 0x401 fault", 32'(f), SplitEn ? 32'h0 : 32'h1);
    checkOutput("lw 0x401 accesses", 32'(grantCount - g), SplitEn ? 32'd2 : 32'd0);

    applyStimulus(1, 32'h301, 32'h0, lat, d, f);
    applyStimulus(6, 32'h303, 32'hABCD5678, lat, d, f);

    fastMem = 1'b0;
    forceGntDelay = 5;
    applyStimulus(7, 32'h600, 32'hA5A55A5A, lat, d, f);
    checkOutput("withheld gnt latency", 32'(lat), 32'd7);
    forceGntDelay = -1;

    // Reset while a load waits for read data; the late data must not produce a response.
    fastMem = 1'b1;
    rdHold = 1'b1;
    m.addr = 32'h500; m.we = 1'b0; m.be = 4'hF; m.wdata = 32'h0;
    memQ.push_back(m);
    ReqValid = 1'b1;
    DataMemControl = 3'd2;
    Addr = 32'h500;
    StoreData = 32'h0;
    @(negedge clk);
    ReqValid = 1'b0;
    @(negedge clk);
    checkOutput("MemReq dropped in WAIT0", 32'(memBus.MemReq), 32'h0);
    checkOutput("ReqReady low in WAIT0", 32'(ReqReady), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset ReqReady", 32'(ReqReady), 32'h1);
    checkOutput("async reset MemReq", 32'(memBus.MemReq), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rdHold = 1'b0;
    lateRValid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("no resp after reset", 32'(RespValid), 32'h0);
      checkOutput("ReqReady after reset", 32'(ReqReady), 32'h1);
    end
    applyStimulus(2, 32'h500, 32'h0, lat, d, f);
    checkOutput("post-reset lw", d, {memRead(32'h503), memRead(32'h502), memRead(32'h501), memRead(32'h500)});

    for (int k = 0; k < 300; k++) begin
      fastMem = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 7), 32'h1000 + $urandom_range(0, 31), $urandom, lat, d, f);
    end

    checkOutput("response queue drained", 32'(respQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width on both request and memory sides.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ReqValid  in  1  core presents a memory op.
REQ-005 SHALL have port: ReqReady  out  1  unit accepts op (high only in IDLE).
REQ-006 SHALL have port: DataMemControl  in  3  op code: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw.
REQ-007 SHALL have port: Addr  in  ADDR_W  byte address (ALU result).
REQ-008 SHALL have port: StoreData  in  32  rs2 value for stores.
REQ-009 SHALL have port: RespValid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: LoadData  out  32  extended load result, valid with RespValid.
REQ-011 SHALL have port: AccessFault  out  1  misalignment error, valid with RespValid.
REQ-012 SHALL have port: MemReq  out  1  memory request, held until MemGnt.
REQ-013 SHALL have port: MemGnt  in  1  memory accepts request this cycle.
REQ-014 SHALL have port: MemWe  out  1  1 = write.
REQ-015 SHALL have port: MemAddr  out  ADDR_W  word-aligned address (low 2 bits 0).
REQ-016 SHALL have port: MemBe  out  4  byte enables.
REQ-017 SHALL have port: MemWData  out  32  lane-shifted store data.
REQ-018 SHALL have port: MemRValid  in  1  read data returned.
REQ-019 SHALL have port: MemRData  in  32  read word.

Function
REQ-020 SHALL capture DataMemControl, Addr, StoreData on ReqValid&&ReqReady; ReqValid ignored otherwise.
REQ-021 SHALL use FSM IDLE -> REQ0 -> WAIT0 -> (REQ1 -> WAIT1) -> RESP -> IDLE; stores skip WAITx (grant completes a write).
REQ-022 SHALL hold MemReq, MemWe, MemAddr, MemBe, MemWData stable in REQx until MemGnt.
REQ-023 SHALL, for loads, advance WAITx -> next state only on MemRValid; MemRValid outside WAITx ignored.
REQ-024 SHALL drive MemBe: byte 4'b0001<<Addr[1:0]; half 4'b0011<<Addr[1:0]; word 4'b1111 (truncated to lanes in current word).
REQ-025 SHALL shift StoreData left by 8*Addr[1:0] into MemWData; unused lanes 0.
REQ-026 SHALL extract load bytes from lane Addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified.
REQ-027 SHALL pulse RespValid exactly one cycle in RESP; ReqReady returns high the following cycle.
REQ-028 SHALL give minimum latency accept->RespValid of 3 cycles for store (gnt same cycle as MemReq), 4 for load (rvalid cycle after gnt).
REQ-029 SHALL treat natural alignment as: half Addr[0]==0, word Addr[1:0]==0.
REQ-030 SHALL treat op codes outside 0..7 as impossible; no X on outputs for any 3-bit code.

Reset
REQ-031 SHALL, on rst_n low, immediately force IDLE, ReqReady=1, RespValid=0, AccessFault=0, MemReq=0, MemWe=0, MemBe=0, MemAddr=0, MemWData=0, LoadData=0.
REQ-032 SHALL abandon any in-flight access on reset; a late MemRValid after reset is ignored; no RespValid for the aborted op.

Configuration
REQ-033 SHALL support macro LSU_MISALIGN_SPLIT_EN.
REQ-034 SHALL, with LSU_MISALIGN_SPLIT_EN defined, split a misaligned access crossing a word boundary into two accesses (REQ0 word Addr&~3, REQ1 word +4), merge lanes, AccessFault=0.
REQ-035 SHALL, without LSU_MISALIGN_SPLIT_EN, issue no memory access for a misaligned op; go IDLE -> RESP with AccessFault=1, LoadData=0.
REQ-036 SHALL, in both builds, execute misaligned-but-in-word halves (Addr[1:0]==1) as one access only when the macro is defined; otherwise fault.

Structure
REQ-037 SHALL place op-code constants (LSU_LB..LSU_SW) and FSM state encoding in shared package lsu_pkg, also used by the control decoder.
REQ-038 SHALL implement lane alignment/extension as combinational sub-module lsu_align (inputs op, offset, raw word(s); outputs LoadData, MemBe, MemWData).

Verification
REQ-039 SHALL cover: sw Addr=0x100 StoreData=0xDEADBEEF, MemGnt immediate -> MemAddr=0x100, MemBe=4'hF, MemWData=0xDEADBEEF, RespValid 3 cycles after accept.
REQ-040 SHALL cover: lb Addr=0x203, MemRData=0x80000000 -> LoadData=0xFFFFFF80; lbu same -> 0x00000080.
REQ-041 SHALL cover: sh Addr=0x302 StoreData=0x1234 -> MemBe=4'b1100, MemWData=0x12340000.
REQ-042 SHALL cover: lw Addr=0x401, words 0x44332211 @0x400, 0x88776655 @0x404 -> split build LoadData=0x55443322, two MemReqs; non-split build AccessFault=1, zero MemReqs.
REQ-043 SHALL cover: MemGnt withheld 5 cycles -> MemReq/MemAddr stable throughout, ReqReady=0.
REQ-044 SHALL cover: rst_n low during WAIT0, then MemRValid -> no RespValid, ReqReady=1, next request correct.
